// File: rtl/pl_pkg.sv
// Shared types for the pl_mem_arb instruction/data memory arbiter.
package pl_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Which requester owns the current access
  typedef enum logic {
    SEL_I = 1'b0,
    SEL_D = 1'b1
  } sel_e;

  // Read-latency counter holds LAT-1, and LAT is at most 4
  localparam int unsigned LAT_CNT_W = 2;

endpackage

// File: rtl/pl_mem_arb.sv
// pl_mem_arb: arbitrates a fetch port and a data port onto one single-port memory.
// Optional feature macro: ARB_FAIRNESS_EN (bounded fetch starvation under data pressure).
module pl_mem_arb
  import pl_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned LAT        = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_ready,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_wmask,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ready,
  output logic            i_stall,
  output logic            d_stall,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_wmask,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int unsigned MW = DW / 8;
  localparam int unsigned CW = LAT_CNT_W;

  if (LAT < 1 || LAT > 4 || STARVE_MAX < 1) begin : g_bad_cfg
    $error("pl_mem_arb: LAT must be 1..4 and STARVE_MAX at least 1");
  end

  state_e          state_q, state_d;
  sel_e            sel_q, sel_d;
  logic            we_q, we_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            i_ready_q, i_ready_d;
  logic            d_ready_q, d_ready_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [MW-1:0]   mem_wmask_q, mem_wmask_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

  logic grant;
  logic win_d;
  logic force_i;

  assign grant = (state_q == ST_IDLE) && (i_req || d_req);
  assign win_d = d_req && !force_i;

`ifdef ARB_FAIRNESS_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;

  assign force_i = i_req && (starve_q == SW'(STARVE_MAX));

  // Count data grants that made a waiting fetch lose; any fetch grant clears it
  always_comb begin
    starve_d = starve_q;
    if (grant) begin
      if (!win_d) begin
        starve_d = '0;
      end else if (i_req && (starve_q != SW'(STARVE_MAX))) begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  // Starvation counter register
  always_ff @(posedge clk) begin
    if (rstn) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_i = 1'b0;
`endif

  // Next-state and registered-output computation for the access sequencer
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_wmask_d = '0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          // The mem_* registers double as the latch for the winner's fields
          state_d     = ST_ISSUE;
          sel_d       = win_d ? SEL_D : SEL_I;
          we_d        = win_d && d_we;
          mem_en_d    = 1'b1;
          mem_we_d    = win_d && d_we;
          mem_addr_d  = win_d ? d_addr : i_addr;
          mem_wmask_d = (win_d && d_we) ? d_wmask : '0;
          mem_wdata_d = (win_d && d_we) ? d_wdata : '0;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d   = ST_DONE;
          d_ready_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CW'(LAT - 1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          if (sel_q == SEL_I) begin
            i_rdata_d = mem_rdata;
            i_ready_d = 1'b1;
          end else begin
            d_rdata_d = mem_rdata;
            d_ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q     <= ST_IDLE;
      sel_q       <= SEL_I;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wmask_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_wmask_q <= mem_wmask_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign i_rdata   = i_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Stalls are combinational so a requester can gate its pipeline in the same cycle
  assign i_stall = i_req && !i_ready_q;
  assign d_stall = d_req && !d_ready_q;

endmodule

// File: tb/tb_pl_mem_arb.sv
// Self-checking bench for pl_mem_arb: directed scenarios plus random traffic
// checked against a transaction-level reference (word memory + grant rules).
module tb_pl_mem_arb;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned LAT  = 2;
  localparam int unsigned SMAX = 4;

  logic          clk;
  logic          rstn;
  logic          i_req;
  logic [31:0]   i_addr;
  logic [31:0]   i_rdata;
  logic          i_ready;
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_wmask;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic [31:0]   d_rdata;
  logic          d_ready;
  logic          i_stall;
  logic          d_stall;
  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  pl_mem_arb #(.AW(AW), .DW(DW), .LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .i_stall(i_stall), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_wmask(mem_wmask),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Environment memory: 256 words, byte-masked writes, read address registered on strobe
  logic [31:0] mem      [256];
  logic [31:0] init_pat [256];
  logic        load_mem;
  logic [7:0]  rd_idx;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int k = 0; k < 256; k++) mem[k] <= init_pat[k];
      rd_idx <= 8'd0;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        rd_idx <= mem_addr[9:2];
      end
    end
  end

  assign mem_rdata = mem[rd_idx];

  // Reference state
  logic [31:0] ref_mem [256];
  logic [31:0] exp_i, exp_d;
  int          starve_m;
  int          n_checks, n_fail;

  // Observation results of the last wait_ready call
  int          ens, bad_stall;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wmask;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Spec rule: data wins a contest unless the fetch has been starved STARVE_MAX times
  function automatic bit d_wins(input bit ireq);
`ifdef ARB_FAIRNESS_EN
    return !(ireq && starve_m == int'(SMAX));
`else
    return (ireq || !ireq);
`endif
  endfunction

  task automatic note_grant(input bit is_d, input bit ireq);
    if (is_d && ireq) starve_m = (starve_m < int'(SMAX)) ? starve_m + 1 : starve_m;
    else if (!is_d) starve_m = 0;
  endtask

  task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
    logic [31:0] w;
    w = ref_mem[a[9:2]];
    for (int b = 0; b < 4; b++)
      if (wm[b]) w[8*b +: 8] = wd[8*b +: 8];
    ref_mem[a[9:2]] = w;
  endtask

  // Advance until the wanted port's ready pulse; cycle count or -1 on timeout
  task automatic wait_ready(input bit want_i, output int cyc);
    cyc = -1;
    ens = 0;
    bad_stall = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (i_stall !== (i_req & ~i_ready)) bad_stall++;
      if (d_stall !== (d_req & ~d_ready)) bad_stall++;
      if (mem_en === 1'b1) begin
        if (ens == 0) begin
          cap_we    = mem_we;
          cap_addr  = mem_addr;
          cap_wdata = mem_wdata;
          cap_wmask = mem_wmask;
        end
        ens++;
      end
      if ((want_i && i_ready === 1'b1) || (!want_i && d_ready === 1'b1)) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic finish_port(input bit is_i, input bit we, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] wm,
                             input int exp_cyc, input string tag);
    int cyc;
    wait_ready(is_i, cyc);
    check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_en_cycles"}, 32'(ens), 32'd1);
    check({tag, "_addr"}, cap_addr, a);
    check({tag, "_stall"}, 32'(bad_stall), 32'd0);
    if (is_i) begin
      exp_i = ref_mem[a[9:2]];
    end else if (!we) begin
      exp_d = ref_mem[a[9:2]];
    end else begin
      check({tag, "_we"}, 32'(cap_we), 32'd1);
      check({tag, "_wdata"}, cap_wdata, wd);
      check({tag, "_wmask"}, 32'(cap_wmask), 32'(wm));
      ref_store(a, wd, wm);
    end
    check({tag, "_i_rdata"}, i_rdata, exp_i);
    check({tag, "_d_rdata"}, d_rdata, exp_d);
  endtask

  // One cycle after a ready pulse: back to quiet outputs
  task automatic end_idle(input string tag);
    tick();
    check({tag, "_i_ready_off"}, 32'(i_ready), 32'd0);
    check({tag, "_d_ready_off"}, 32'(d_ready), 32'd0);
    check({tag, "_mem_en_off"}, 32'(mem_en), 32'd0);
  endtask

  initial begin
    int          grants, cyc, op, dl;
    bit          got_d, exp_win, any_i, we;
    logic [31:0] ia, da, wd;
    logic [3:0]  wm;

    n_checks = 0;
    n_fail   = 0;
    starve_m = 0;
    exp_i    = '0;
    exp_d    = '0;
    for (int k = 0; k < 256; k++) begin
      init_pat[k] = $urandom;
      ref_mem[k]  = init_pat[k];
    end
    init_pat[1] = 32'h0050_0093;
    ref_mem[1]  = 32'h0050_0093;

    // Reset
    rstn = 1'b1; load_mem = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_wmask = '0; d_addr = '0; d_wdata = '0;
    repeat (3) tick();
    load_mem = 1'b0;
    check("rst_i_ready", 32'(i_ready), 32'd0);
    check("rst_d_ready", 32'(d_ready), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    rstn = 1'b0;
    tick();

    // Single fetch: ready LAT+2 cycles after sampling
    i_req = 1'b1; i_addr = 32'h0000_0004;
    note_grant(1'b0, 1'b1);
    finish_port(1'b1, 1'b0, 32'h4, '0, '0, int'(LAT) + 2, "fetch");
    check("fetch_data", i_rdata, 32'h0050_0093);
    i_req = 1'b0;
    end_idle("fetch");

    // Full-word store: ready 2 cycles after sampling
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'hF;
    note_grant(1'b1, 1'b0);
    finish_port(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 2, "store");
    d_req = 1'b0; d_we = 1'b0;
    end_idle("store");

    // Partial store then load-back of the merged word
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h1122_3344; d_wmask = 4'b0101;
    note_grant(1'b1, 1'b0);
    finish_port(1'b0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 2, "pstore");
    d_req = 1'b0; d_we = 1'b0;
    end_idle("pstore");
    d_req = 1'b1; d_addr = 32'h10;
    note_grant(1'b1, 1'b0);
    finish_port(1'b0, 1'b0, 32'h10, '0, '0, int'(LAT) + 2, "pload");
    check("pload_merged", d_rdata, 32'hDE22_BE44);
    d_req = 1'b0;
    end_idle("pload");

    // Simultaneous requests: data first, fetch granted in the IDLE after d_ready
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    i_req = 1'b1; i_addr = 32'h104;
    exp_win = d_wins(1'b1);
    check("both_first_is_d", 32'(exp_win), 32'd1);
    note_grant(1'b1, 1'b1);
    finish_port(1'b0, 1'b0, 32'h100, '0, '0, int'(LAT) + 2, "both_d");
    check("both_i_stall_high", 32'(i_stall), 32'd1);
    d_req = 1'b0;
    note_grant(1'b0, 1'b1);
    finish_port(1'b1, 1'b0, 32'h104, '0, '0, int'(LAT) + 3, "both_i");
    i_req = 1'b0;
    end_idle("both");

    // Reset while waiting on a load: abandoned, then the held request is re-served
    d_req = 1'b1; d_addr = 32'h20;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    exp_i = '0; exp_d = '0; starve_m = 0;
    check("rstw_mem_en", 32'(mem_en), 32'd0);
    check("rstw_d_ready", 32'(d_ready), 32'd0);
    check("rstw_d_rdata", d_rdata, 32'd0);
    check("rstw_i_rdata", i_rdata, 32'd0);
    note_grant(1'b1, 1'b0);
    finish_port(1'b0, 1'b0, 32'h20, '0, '0, int'(LAT) + 2, "rstw_reserve");
    d_req = 1'b0;
    end_idle("rstw");

    // Continuous contention: grant order follows the starvation rule
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    i_req = 1'b1; i_addr = 32'h300;
    grants = 0;
    any_i  = 1'b0;
    for (int n = 0; n < 300 && grants < 12; n++) begin
      tick();
      if (mem_en === 1'b1) begin
        got_d   = (mem_addr == 32'h200);
        exp_win = d_wins(1'b1);
        check($sformatf("grant%0d_is_d", grants), 32'(got_d), 32'(exp_win));
        note_grant(exp_win, 1'b1);
        if (!exp_win) any_i = 1'b1;
        grants++;
        if (grants == 12) begin
          d_req = 1'b0;
          i_req = 1'b0;
        end
      end
    end
    check("grant_count", 32'(grants), 32'd12);
    cyc = -1;
    for (int n = 1; n <= int'(LAT) + 4; n++) begin
      tick();
      if (i_ready === 1'b1 || d_ready === 1'b1) begin
        cyc = n;
        break;
      end
    end
    check("grant_tail_ready", 32'(cyc > 0), 32'd1);
    exp_d = ref_mem[8'h80];
    if (any_i) exp_i = ref_mem[8'hC0];
    end_idle("grant_tail");
    check("grant_tail_d_rdata", d_rdata, exp_d);
    check("grant_tail_i_rdata", i_rdata, exp_i);

    // Random traffic against the reference memory and arbitration rules
    for (int t = 0; t < 40; t++) begin
      op = int'($urandom_range(0, 3));
      ia = 32'($urandom_range(0, 255)) << 2;
      da = 32'($urandom_range(0, 255)) << 2;
      wd = $urandom;
      wm = 4'($urandom_range(1, 15));
      we = (op == 2) || (op == 3 && $urandom_range(0, 1) == 1);
      dl = we ? 2 : int'(LAT) + 2;
      if (op == 0) begin
        i_req = 1'b1; i_addr = ia;
        note_grant(1'b0, 1'b1);
        finish_port(1'b1, 1'b0, ia, '0, '0, int'(LAT) + 2, $sformatf("r%0d_i", t));
      end else if (op != 3) begin
        d_req = 1'b1; d_we = we; d_addr = da; d_wdata = wd; d_wmask = wm;
        note_grant(1'b1, 1'b0);
        finish_port(1'b0, we, da, wd, wm, dl, $sformatf("r%0d_d", t));
      end else begin
        i_req = 1'b1; i_addr = ia;
        d_req = 1'b1; d_we = we; d_addr = da; d_wdata = wd; d_wmask = wm;
        if (d_wins(1'b1)) begin
          note_grant(1'b1, 1'b1);
          finish_port(1'b0, we, da, wd, wm, dl, $sformatf("r%0d_bd", t));
          d_req = 1'b0;
          note_grant(1'b0, 1'b1);
          finish_port(1'b1, 1'b0, ia, '0, '0, int'(LAT) + 3, $sformatf("r%0d_bi", t));
        end else begin
          note_grant(1'b0, 1'b1);
          finish_port(1'b1, 1'b0, ia, '0, '0, int'(LAT) + 2, $sformatf("r%0d_fi", t));
          i_req = 1'b0;
          note_grant(1'b1, 1'b0);
          finish_port(1'b0, we, da, wd, wm, dl + 1, $sformatf("r%0d_fd", t));
        end
      end
      i_req = 1'b0;
      d_req = 1'b0;
      d_we  = 1'b0;
      end_idle($sformatf("r%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
